plic_gateway: RTL and testbench

Per-source interrupt gateway of the PLIC. Converts raw level- or edge-triggered device interrupt lines into pending bits, one per source. It holds each source out of the pending set from claim until completion. It sits directly upstream of the PLIC register map: `ip_o` drives its pending-read input, and the claim/complete strobes decoded from the claim/complete register accesses drive `claim_*`/`complete_*`.

---
 rtl/plic_pkg.sv | 12 +
 rtl/plic_gateway_cell.sv | 83 ++++++++
 rtl/plic_gateway.sv | 54 +++++
 tb/tb_plic_gateway.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_pkg;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_BUSY = 2'd2
    } gw_state_e;

    localparam int GW_ID_NONE = 0;

endpackage

// File: rtl/plic_gateway_cell.sv
// One gateway source: IDLE/PEND/BUSY FSM with rising-edge detection and a
// saturating queue of edges that arrived while the source could not pend.
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    gw_state_e        state_q, state_d;
    logic             src_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_det;
    logic             consume_edge;
    logic             take_cnt;
    logic             queue_edge;

    assign edge_det = src_i & ~src_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        consume_edge = 1'b0;
        take_cnt     = 1'b0;
        queue_edge   = 1'b0;

        case (state_q)
            GW_IDLE: begin
                if (le_i) begin
                    if (edge_det) begin
                        state_d      = GW_PEND;
                        consume_edge = 1'b1;
                    end else if (cnt_q != '0) begin
                        state_d  = GW_PEND;
                        take_cnt = 1'b1;
                    end
                end else if (src_i) begin
                    state_d = GW_PEND;
                end
            end
            GW_PEND: if (claim_i)    state_d = GW_BUSY;
            GW_BUSY: if (complete_i) state_d = GW_IDLE;
            default: state_d = GW_IDLE;
        endcase

        // An edge not used to leave IDLE directly is remembered for later.
        queue_edge = le_i & edge_det & ~consume_edge;

        if (!le_i) begin
            cnt_d = '0;
        end else if (queue_edge && !take_cnt) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (take_cnt && !queue_edge) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= GW_IDLE;
            src_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_i;
            cnt_q   <= cnt_d;
        end
    end

    assign ip_o   = (state_q == GW_PEND);
    assign busy_o = (state_q == GW_BUSY);

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway: decodes claim/complete IDs to per-source strobes and holds
// one gateway cell per interrupt source.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int N_SOURCE = 3,
    parameter int SRC_W    = $clog2(N_SOURCE + 1),
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic                claim_valid_i,
    input  logic [SRC_W-1:0]    claim_id_i,
    input  logic                complete_valid_i,
    input  logic [SRC_W-1:0]    complete_id_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] busy_o
);

    logic [N_SOURCE-1:0] claim_vec;
    logic [N_SOURCE-1:0] complete_vec;

    // IDs outside 1..N_SOURCE match no bit and are therefore dropped.
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int k = 0; k < N_SOURCE; k++) begin
            claim_vec[k]    = claim_valid_i
                              && (claim_id_i != SRC_W'(GW_ID_NONE))
                              && (claim_id_i == SRC_W'(k + 1));
            complete_vec[k] = complete_valid_i
                              && (complete_id_i != SRC_W'(GW_ID_NONE))
                              && (complete_id_i == SRC_W'(k + 1));
        end
    end

    for (genvar g = 0; g < N_SOURCE; g++) begin : g_cell
        plic_gateway_cell #(
            .CNT_W(CNT_W)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (src_i[g]),
            .le_i       (le_i[g]),
            .claim_i    (claim_vec[g]),
            .complete_i (complete_vec[g]),
            .ip_o       (ip_o[g]),
            .busy_o     (busy_o[g])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway (N_SOURCE=3, CNT_W=2).
module tb_plic_gateway;

    localparam int N_SOURCE = 3;
    localparam int SRC_W    = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N_SOURCE-1:0] src_i;
    logic [N_SOURCE-1:0] le_i;
    logic                claim_valid_i;
    logic [SRC_W-1:0]    claim_id_i;
    logic                complete_valid_i;
    logic [SRC_W-1:0]    complete_id_i;
    logic [N_SOURCE-1:0] ip_o;
    logic [N_SOURCE-1:0] busy_o;

    int checks   = 0;
    int failures = 0;

    plic_gateway #(
        .N_SOURCE(N_SOURCE),
        .CNT_W   (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .src_i           (src_i),
        .le_i            (le_i),
        .claim_valid_i   (claim_valid_i),
        .claim_id_i      (claim_id_i),
        .complete_valid_i(complete_valid_i),
        .complete_id_i   (complete_id_i),
        .ip_o            (ip_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [N_SOURCE-1:0] mask);
        src_i = mask;
        step();
        src_i = '0;
        step();
    endtask

    task automatic claim(input logic [SRC_W-1:0] id);
        claim_valid_i = 1'b1;
        claim_id_i    = id;
        step();
        claim_valid_i = 1'b0;
        claim_id_i    = '0;
    endtask

    task automatic complete(input logic [SRC_W-1:0] id);
        complete_valid_i = 1'b1;
        complete_id_i    = id;
        step();
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni           = 1'b0;
        src_i            = '0;
        le_i             = '0;
        claim_valid_i    = 1'b0;
        claim_id_i       = '0;
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
        step();
        step();
        chk("reset_ip", 8'(ip_o), 8'b000);
        chk("reset_busy", 8'(busy_o), 8'b000);
        rst_ni = 1'b1;

        // Level mode on source 1
        src_i = 3'b001;
        step();
        chk("lvl_ip", 8'(ip_o), 8'b001);
        chk("lvl_busy", 8'(busy_o), 8'b000);
        claim(2'd1);
        chk("lvl_claim_ip", 8'(ip_o), 8'b000);
        chk("lvl_claim_busy", 8'(busy_o), 8'b001);
        complete(2'd1);
        chk("lvl_cmpl_busy", 8'(busy_o), 8'b000);
        chk("lvl_cmpl_idle_ip", 8'(ip_o), 8'b000);
        step();
        chk("lvl_repend_ip", 8'(ip_o), 8'b001);
        claim(2'd1);
        src_i = '0;
        complete(2'd1);
        step();
        chk("lvl_quiet_ip", 8'(ip_o), 8'b000);
        chk("lvl_quiet_busy", 8'(busy_o), 8'b000);

        // Sticky pending from a one-cycle level pulse on source 3
        pulse(3'b100);
        chk("sticky_ip_a", 8'(ip_o), 8'b100);
        step();
        chk("sticky_ip_b", 8'(ip_o), 8'b100);
        claim(2'd3);
        chk("sticky_claim_ip", 8'(ip_o), 8'b000);
        chk("sticky_claim_busy", 8'(busy_o), 8'b100);
        complete(2'd3);
        step();
        chk("sticky_done_ip", 8'(ip_o), 8'b000);
        chk("sticky_done_busy", 8'(busy_o), 8'b000);

        // Illegal IDs: source 2 pending, others idle
        pulse(3'b010);
        chk("ill_setup_ip", 8'(ip_o), 8'b010);
        claim(2'd0);
        chk("ill_id0_ip", 8'(ip_o), 8'b010);
        chk("ill_id0_busy", 8'(busy_o), 8'b000);
        claim(2'd3);
        chk("ill_idle3_ip", 8'(ip_o), 8'b010);
        chk("ill_idle3_busy", 8'(busy_o), 8'b000);
        complete(2'd2);
        chk("ill_cmplpend_ip", 8'(ip_o), 8'b010);
        chk("ill_cmplpend_busy", 8'(busy_o), 8'b000);

        // Simultaneous strobes on different IDs
        claim(2'd2);
        chk("sim_setup_busy", 8'(busy_o), 8'b010);
        pulse(3'b001);
        chk("sim_setup_ip", 8'(ip_o), 8'b001);
        claim_valid_i    = 1'b1;
        claim_id_i       = 2'd1;
        complete_valid_i = 1'b1;
        complete_id_i    = 2'd2;
        step();
        claim_valid_i    = 1'b0;
        complete_valid_i = 1'b0;
        chk("sim_diff_busy", 8'(busy_o), 8'b001);
        chk("sim_diff_ip", 8'(ip_o), 8'b000);
        complete(2'd1);
        chk("sim_diff_done", 8'(busy_o), 8'b000);

        // Same ID claimed and completed together: only the legal move applies
        pulse(3'b001);
        chk("same_setup_ip", 8'(ip_o), 8'b001);
        claim_valid_i    = 1'b1;
        claim_id_i       = 2'd1;
        complete_valid_i = 1'b1;
        complete_id_i    = 2'd1;
        step();
        chk("same_pend_busy", 8'(busy_o), 8'b001);
        chk("same_pend_ip", 8'(ip_o), 8'b000);
        step();
        claim_valid_i    = 1'b0;
        complete_valid_i = 1'b0;
        chk("same_busy_busy", 8'(busy_o), 8'b000);
        chk("same_busy_ip", 8'(ip_o), 8'b000);
        step();
        chk("same_idle_ip", 8'(ip_o), 8'b000);

        // Edge queueing on source 2: five edges while busy saturate at 3
        le_i = 3'b111;
        pulse(3'b010);
        chk("edge_pend_ip", 8'(ip_o), 8'b010);
        claim(2'd2);
        chk("edge_claim_busy", 8'(busy_o), 8'b010);
        for (int p = 0; p < 5; p++) pulse(3'b010);
        chk("edge_queue_ip", 8'(ip_o), 8'b000);
        for (int r = 0; r < 4; r++) begin
            complete(2'd2);
            chk($sformatf("edge_r%0d_idle_busy", r), 8'(busy_o), 8'b000);
            chk($sformatf("edge_r%0d_idle_ip", r), 8'(ip_o), 8'b000);
            step();
            chk($sformatf("edge_r%0d_ip", r), 8'(ip_o), (r < 3) ? 8'b010 : 8'b000);
            if (r < 3) begin
                claim(2'd2);
                chk($sformatf("edge_r%0d_busy", r), 8'(busy_o), 8'b010);
            end else begin
                step();
                chk("edge_r3_still_idle", 8'(ip_o), 8'b000);
            end
        end

        // Reset mid-operation with queued edges and a line held high
        pulse(3'b111);
        chk("rst_setup_ip", 8'(ip_o), 8'b111);
        claim(2'd1);
        claim(2'd3);
        chk("rst_setup_busy", 8'(busy_o), 8'b101);
        chk("rst_setup_ip2", 8'(ip_o), 8'b010);
        pulse(3'b101);
        pulse(3'b101);
        src_i = 3'b010;
        step();
        rst_ni = 1'b0;
        step();
        chk("rst_mid_ip", 8'(ip_o), 8'b000);
        chk("rst_mid_busy", 8'(busy_o), 8'b000);
        rst_ni = 1'b1;
        step();
        chk("rst_after_ip", 8'(ip_o), 8'b010);
        chk("rst_after_busy", 8'(busy_o), 8'b000);
        claim(2'd2);
        chk("rst_claim_busy", 8'(busy_o), 8'b010);
        complete(2'd2);
        step();
        chk("rst_once_ip", 8'(ip_o), 8'b000);
        step();
        chk("rst_once_ip2", 8'(ip_o), 8'b000);
        chk("rst_once_busy", 8'(busy_o), 8'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
